// File: rtl/softmax_pkg.sv
// Shared widths, Q-format shift, controller state encoding and unsigned saturation for the softmax row-sum path.
package softmax_pkg;
  localparam int SM_IN_W  = 16;
  localparam int SM_OUT_W = 32;
  localparam int Q_SHIFT  = 14;  // Q4.12 element aligned to Q6.26 sum
  localparam int SAT_W    = 64;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_e;

  // Clamps v to the largest unsigned value that fits in w bits.
  function automatic logic [SAT_W-1:0] sat_unsigned(input logic [SAT_W-1:0] v, input int unsigned w);
    logic [SAT_W-1:0] mask;
    mask = {SAT_W{1'b1}} >> (SAT_W - w);
    return (|(v & ~mask)) ? mask : v;
  endfunction
endpackage

// File: rtl/sum_tree_pipe.sv
// Clamps negative Q4.12 elements to zero, aligns to Q6.26 and sums them in an L-stage registered tree.
// Latency L=$clog2(N); no backpressure, a result emerges L cycles after every valid input.
module sum_tree_pipe
  import softmax_pkg::*;
#(
  parameter int N     = 4,
  parameter int IN_W  = SM_IN_W,
  parameter int OUT_W = SM_OUT_W,
  parameter int L     = $clog2(N),
  parameter int TW    = OUT_W + L
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_vld,
  input  logic [N-1:0][IN_W-1:0]   i_data,
  output logic                     o_vld,
  output logic [TW-1:0]            o_res
);
  logic [TW-1:0] conv [N];
  // Level s occupies node[N-(2N>>s) +: N>>s]; the root is node[N-2].
  logic [TW-1:0] node [N-1];
  logic [L-1:0]  vld_q;

  for (genvar i = 0; i < N; i++) begin : g_conv
    logic [OUT_W-1:0] ext;
    assign ext     = {{(OUT_W-IN_W){1'b0}}, i_data[i]};
    assign conv[i] = i_data[i][IN_W-1] ? '0 : {{L{1'b0}}, ext << Q_SHIFT};
  end

  for (genvar s = 1; s <= L; s++) begin : g_lvl
    for (genvar j = 0; j < (N >> s); j++) begin : g_node
      logic [TW-1:0] a, b;
      if (s == 1) begin : g_leaf
        assign a = conv[2*j];
        assign b = conv[2*j+1];
      end else begin : g_inner
        assign a = node[N - (2*N >> (s-1)) + 2*j];
        assign b = node[N - (2*N >> (s-1)) + 2*j + 1];
      end
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) node[N - (2*N >> s) + j] <= '0;
        else       node[N - (2*N >> s) + j] <= a + b;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= i_vld;
      for (int k = 1; k < L; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  assign o_vld = vld_q[L-1];
  assign o_res = node[N-2];
endmodule

// File: rtl/softmax_sum_ctrl.sv
// Sequences one softmax row of K chunks through the adder tree and emits one saturated Q6.26 sum.
// o_valid rises K+L cycles after the first back-to-back chunk; o_ready drops from row end until o_sum is taken.
module softmax_sum_ctrl
  import softmax_pkg::*;
#(
  parameter int N          = 4,
  parameter int IN_W       = SM_IN_W,
  parameter int OUT_W      = SM_OUT_W,
  parameter int MAX_CHUNKS = 8,
  parameter int CW         = $clog2(MAX_CHUNKS) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [CW-1:0]          i_cfg_chunks,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N-1:0][IN_W-1:0] i_data,
  output logic [OUT_W-1:0]       o_sum,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy
);
  localparam int L  = $clog2(N);
  localparam int TW = OUT_W + L;
  localparam int AW = OUT_W + $clog2(MAX_CHUNKS);
  localparam int SW = AW + L + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   k_q, sent_q, ret_q, cfg_k;
  logic [AW-1:0]   acc_q;
  logic            tree_vld, accept, last_ret, out_hs;
  logic [TW-1:0]   tree_res;
  logic [SW-1:0]   sum_full;
  logic [SAT_W-1:0] sum_sat;
  logic            sat_hi_unused;

  sum_tree_pipe #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .L(L), .TW(TW)) u_tree (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (accept),
    .i_data (i_data),
    .o_vld  (tree_vld),
    .o_res  (tree_res)
  );

  assign accept   = i_valid && o_ready;
  assign cfg_k    = (i_cfg_chunks == '0) ? CW'(1) :
                    (i_cfg_chunks > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : i_cfg_chunks;
  assign last_ret = tree_vld && ((ret_q + CW'(1)) == k_q);
  assign out_hs   = (state_q == OUT) && i_ready;
  assign sum_full = SW'(acc_q) + SW'(tree_res);
  assign sum_sat  = sat_unsigned(SAT_W'(sum_full), OUT_W);
  assign sat_hi_unused = ^sum_sat[SAT_W-1:OUT_W];

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = (cfg_k == CW'(1)) ? DRAIN : FEED;
      end
      FEED: begin
        o_ready = 1'b1;
        if (i_valid && ((sent_q + CW'(1)) == k_q)) state_d = DRAIN;
      end
      DRAIN: if (last_ret) state_d = OUT;
      OUT: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Chunk issue and tree-result accumulation advance independently every cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      sent_q  <= '0;
      ret_q   <= '0;
      acc_q   <= '0;
      o_sum   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (state_q == IDLE) begin
          k_q    <= cfg_k;
          sent_q <= CW'(1);
        end else begin
          sent_q <= sent_q + CW'(1);
        end
      end
      if (tree_vld) begin
        acc_q <= sum_full[AW-1:0];
        ret_q <= ret_q + CW'(1);
      end
      if (last_ret) o_sum <= sum_sat[OUT_W-1:0];
      if (out_hs) begin
        acc_q  <= '0;
        sent_q <= '0;
        ret_q  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_softmax_sum_ctrl.sv
// Directed bench for softmax_sum_ctrl: latency, clamping, gaps, saturation, backpressure and reset abort.
module tb_softmax_sum_ctrl;
  localparam int N = 4, IN_W = 16, OUT_W = 32, MAX_CHUNKS = 8, CW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [CW-1:0]          cfg_chunks;
  logic                   valid, ready, o_valid, i_ready, busy;
  logic [N-1:0][IN_W-1:0] data;
  logic [OUT_W-1:0]       sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  softmax_sum_ctrl #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_CHUNKS(MAX_CHUNKS), .CW(CW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cfg_chunks (cfg_chunks),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_data       (data),
    .o_sum        (sum),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Holds one chunk until accepted; t_acc is the cycle whose edge accepted it.
  task automatic put_chunk(input logic [CW-1:0] cfg, input logic [N-1:0][IN_W-1:0] d,
                           output bit ok, output int t_acc);
    ok = 1'b0;
    t_acc = -1;
    cfg_chunks = cfg;
    data = d;
    valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ready) begin
        ok = 1'b1;
        t_acc = cyc;
      end
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 50 && !o_valid; i++) tick();
    ok = o_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (sum !== 32'h0 || o_valid !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: sum=%h valid=%b busy=%b ready=%b, need 0/0/0/1", sum, o_valid, busy, ready);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (sum !== 32'h0 || o_valid !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: sum=%h valid=%b busy=%b ready=%b, need 0/0/0/1", sum, o_valid, busy, ready);
    end
  endtask

  task automatic test_single_chunk();
    bit ok; int t0;
    put_chunk(4'd1, {4{16'h1000}}, ok, t0);
    checks++;
    if (!ok) begin errors++; $display("FAIL k1_accept: not accepted, need accept"); end
    checks++;
    if (o_valid !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL k1_drain: valid=%b ready=%b busy=%b, need 0/0/1", o_valid, ready, busy);
    end
    wait_valid(ok);
    checks++;
    if (!ok || cyc - t0 != 3) begin errors++; $display("FAIL k1_latency: got %0d, need 3", cyc - t0); end
    checks++;
    if (sum !== 32'h1000_0000) begin errors++; $display("FAIL k1_sum: got %h, need 10000000", sum); end
    tick();
    checks++;
    if (o_valid !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL k1_idle: valid=%b ready=%b busy=%b, need 0/1/0", o_valid, ready, busy);
    end
  endtask

  task automatic test_negative_clamp();
    bit ok; int t0;
    put_chunk(4'd1, {16'h0000, 16'h0800, 16'hF000, 16'h1000}, ok, t0);
    wait_valid(ok);
    checks++;
    if (!ok || sum !== 32'h0600_0000) begin errors++; $display("FAIL neg_clamp_sum: got %h, need 06000000", sum); end
    tick();
  endtask

  task automatic test_gaps();
    bit ok; int t0, t3, gap_bad, rdy_bad;
    gap_bad = 0; rdy_bad = 0;
    put_chunk(4'd3, {4{16'h1000}}, ok, t0);
    for (int g = 0; g < 2; g++) begin
      if (ready !== 1'b1 || busy !== 1'b1) gap_bad++;
      tick();
    end
    put_chunk(4'd3, {4{16'h1000}}, ok, t3);
    if (ready !== 1'b1 || busy !== 1'b1) gap_bad++;
    tick();
    put_chunk(4'd3, {4{16'h1000}}, ok, t3);
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL gap_feed: %0d bad gap cycles, need 0", gap_bad); end
    for (int i = 0; i < 50 && !o_valid; i++) begin
      if (ready !== 1'b0) rdy_bad++;
      tick();
    end
    if (ready !== 1'b0) rdy_bad++;
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL gap_ready_low: %0d cycles ready=1, need 0", rdy_bad); end
    checks++;
    if (o_valid !== 1'b1 || cyc - t3 != 3) begin errors++; $display("FAIL gap_latency: got %0d, need 3", cyc - t3); end
    checks++;
    if (sum !== 32'h3000_0000) begin errors++; $display("FAIL gap_sum: got %h, need 30000000", sum); end
    tick();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL gap_ready_back: got %b, need 1", ready); end
  endtask

  task automatic test_saturate_and_clamp();
    bit ok; int t0, tk;
    put_chunk(4'd8, {4{16'h7FFF}}, ok, t0);
    for (int c = 1; c < 8; c++) put_chunk(4'd8, {4{16'h7FFF}}, ok, tk);
    wait_valid(ok);
    checks++;
    if (!ok || cyc - t0 != 10) begin errors++; $display("FAIL k8_latency: got %0d, need 10", cyc - t0); end
    checks++;
    if (sum !== 32'hFFFF_FFFF) begin errors++; $display("FAIL k8_saturate: got %h, need ffffffff", sum); end
    tick();
    put_chunk(4'd0, {4{16'h1000}}, ok, t0);
    wait_valid(ok);
    checks++;
    if (!ok || cyc - t0 != 3 || sum !== 32'h1000_0000) begin
      errors++;
      $display("FAIL cfg0_as_1: lat=%0d sum=%h, need 3 10000000", cyc - t0, sum);
    end
    tick();
    put_chunk(4'd15, {4{16'h0400}}, ok, t0);
    for (int c = 1; c < 8; c++) put_chunk(4'd15, {4{16'h0400}}, ok, tk);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cfg15_drain: ready=%b busy=%b, need 0/1", ready, busy);
    end
    wait_valid(ok);
    checks++;
    if (!ok || cyc - t0 != 10 || sum !== 32'h2000_0000) begin
      errors++;
      $display("FAIL cfg15_as_8: lat=%0d sum=%h, need 10 20000000", cyc - t0, sum);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok; int t0, bad;
    bad = 0;
    i_ready = 1'b0;
    put_chunk(4'd1, {4{16'h0400}}, ok, t0);
    wait_valid(ok);
    for (int i = 0; i < 5; i++) begin
      if (o_valid !== 1'b1 || sum !== 32'h0400_0000 || ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (!ok || bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, need 0", bad); end
    checks++;
    if (o_valid !== 1'b1 || sum !== 32'h0400_0000) begin
      errors++;
      $display("FAIL bp_cycle6: valid=%b sum=%h, need 1 04000000", o_valid, sum);
    end
    i_ready = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b, need 0/1", o_valid, ready);
    end
    put_chunk(4'd2, {4{16'h2000}}, ok, t0);
    put_chunk(4'd2, {4{16'h0001}}, ok, t0);
    wait_valid(ok);
    checks++;
    if (!ok || sum !== 32'h2001_0000) begin errors++; $display("FAIL bp_next_row: got %h, need 20010000", sum); end
    tick();
  endtask

  task automatic test_reset_mid_row();
    bit ok, seen; int t0;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) put_chunk(4'd3, {4{16'h1000}}, ok, t0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (sum !== 32'h0 || o_valid !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs: sum=%h valid=%b busy=%b ready=%b, need 0/0/0/1", sum, o_valid, busy, ready);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (o_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_no_valid: activity after reset, need none"); end
    put_chunk(4'd1, {4{16'h0800}}, ok, t0);
    wait_valid(ok);
    checks++;
    if (!ok || cyc - t0 != 3 || sum !== 32'h0800_0000) begin
      errors++;
      $display("FAIL midrst_next_row: lat=%0d sum=%h, need 3 08000000", cyc - t0, sum);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    valid = 1'b0;
    i_ready = 1'b1;
    cfg_chunks = '0;
    data = '0;
    test_reset();
    test_single_chunk();
    test_negative_clamp();
    test_gaps();
    test_saturate_and_clamp();
    test_backpressure();
    test_reset_mid_row();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
